// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared widths and state encodings for the shift-add multiplier
package mult_pkg;

  localparam int MULT_WIDTH = 4;

  typedef enum logic [1:0] {
    PH_IDLE     = 2'b00,
    PH_LOADED   = 2'b01,
    PH_SHIFTING = 2'b10
  } phase_t;

  // Encodings used by multiplier_controller; kept here so both sides agree.
  typedef enum logic [1:0] {
    CTRL_IDLE  = 2'b00,
    CTRL_INIT  = 2'b01,
    CTRL_SHIFT = 2'b10,
    CTRL_DONE  = 2'b11
  } ctrl_state_t;

endpackage

// File: rtl/mult_result_reg.sv
// rtl/mult_result_reg.sv - product holding register with valid/ack handshake
module mult_result_reg #(
  parameter int PW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [PW-1:0] load_data,
  input  logic          ack,
  output logic [PW-1:0] product,
  output logic          product_valid,
  output logic          overrun
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      product       <= '0;
      product_valid <= 1'b0;
      overrun       <= 1'b0;
    end else if (load) begin
      product       <= load_data;
      product_valid <= 1'b1;
      // An unacknowledged result is being replaced.
      if (product_valid && !ack)
        overrun <= 1'b1;
    end else if (product_valid && ack) begin
      product_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_add_multiplier_datapath.sv
// rtl/shift_add_multiplier_datapath.sv - unsigned shift-and-add multiply driven by controller strobes
module shift_add_multiplier_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               init,
  input  logic               SR,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               product_valid,
  input  logic               product_ack,
  output logic               busy,
  output logic [CW-1:0]      step_count,
  output logic               seq_error,
  output logic               overrun
);

  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  phase_t           phase, phase_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH:0]   sum;
  logic             do_load, do_step, do_final, err_set;

  assign sum = acc + {1'b0, (q_reg[0] ? a_reg : '0)};

  always_ff @(posedge clock) begin
    if (!reset) phase <= PH_IDLE;
    else        phase <= phase_next;
  end

  always_comb begin
    phase_next = phase;
    if (do_load)
      phase_next = PH_LOADED;
    else if (init && SR)
      phase_next = PH_IDLE;
    else if (do_step)
      phase_next = PH_SHIFTING;
  end

  always_comb begin
    do_load  = 1'b0;
    do_step  = 1'b0;
    do_final = 1'b0;
    err_set  = 1'b0;
    busy     = (phase != PH_IDLE);
    if (init && !SR) begin
      do_load = 1'b1;
    end else if (SR) begin
      if (phase == PH_IDLE) begin
        err_set = 1'b1;
      end else if (init) begin
        if (step_count == LAST_STEP) begin
          do_step  = 1'b1;
          do_final = 1'b1;
        end else begin
          err_set = 1'b1;
        end
      end else begin
        do_step = 1'b1;
        // Last step arrived without init: the controller should have finalized.
        if (step_count == LAST_STEP)
          err_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      a_reg      <= '0;
      acc        <= '0;
      q_reg      <= '0;
      step_count <= '0;
      seq_error  <= 1'b0;
    end else begin
      if (do_load) begin
        a_reg      <= multiplicand;
        q_reg      <= multiplier;
        acc        <= '0;
        step_count <= '0;
      end else if (do_step) begin
        acc        <= {1'b0, sum[WIDTH:1]};
        q_reg      <= {sum[0], q_reg[WIDTH-1:1]};
        step_count <= step_count + 1'b1;
      end
      if (err_set)
        seq_error <= 1'b1;
    end
  end

  // Post-step {acc,Q} with the always-zero carry dropped.
  mult_result_reg #(.PW(2 * WIDTH)) u_result (
    .clock         (clock),
    .reset         (reset),
    .load          (do_final),
    .load_data     ({sum, q_reg[WIDTH-1:1]}),
    .ack           (product_ack),
    .product       (product),
    .product_valid (product_valid),
    .overrun       (overrun)
  );

endmodule

// File: tb/tb_shift_add_multiplier_datapath.sv
// tb/tb_shift_add_multiplier_datapath.sv - self-checking bench for shift_add_multiplier_datapath
module tb_shift_add_multiplier_datapath;

  localparam int W = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           init = 1'b0;
  logic           SR = 1'b0;
  logic [W-1:0]   multiplicand = '0;
  logic [W-1:0]   multiplier = '0;
  logic [2*W-1:0] product;
  logic           product_valid;
  logic           product_ack = 1'b0;
  logic           busy;
  logic [2:0]     step_count;
  logic           seq_error;
  logic           overrun;

  int n_checks = 0;
  int n_fail = 0;

  // Behavioural reference: operands, step tally and product by plain arithmetic.
  int m_a, m_b, m_steps, m_prod;
  bit m_busy, m_valid, m_seq, m_over;

  typedef struct {
    int a;
    int b;
    int exp;
  } vec_t;

  vec_t vecs[5];

  shift_add_multiplier_datapath dut (
    .clock         (clock),
    .reset         (reset),
    .init          (init),
    .SR            (SR),
    .multiplicand  (multiplicand),
    .multiplier    (multiplier),
    .product       (product),
    .product_valid (product_valid),
    .product_ack   (product_ack),
    .busy          (busy),
    .step_count    (step_count),
    .seq_error     (seq_error),
    .overrun       (overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input bit i, input bit s, input bit k, input int a, input int b, input bit r);
    bit fin;
    fin = 0;
    if (!r) begin
      m_a = 0; m_b = 0; m_steps = 0; m_prod = 0;
      m_busy = 0; m_valid = 0; m_seq = 0; m_over = 0;
      return;
    end
    if (i && !s) begin
      m_a = a; m_b = b; m_steps = 0; m_busy = 1;
    end else if (s) begin
      if (!m_busy) begin
        m_seq = 1;
      end else if (i) begin
        if (m_steps == W - 1) begin
          fin = 1;
          m_steps++;
        end else begin
          m_seq = 1;
        end
        m_busy = 0;
      end else begin
        if (m_steps == W - 1) m_seq = 1;
        m_steps++;
      end
    end
    if (fin) begin
      if (m_valid && !k) m_over = 1;
      m_prod = m_a * m_b;
      m_valid = 1;
    end else if (m_valid && k) begin
      m_valid = 0;
    end
  endtask

  task automatic check_all();
    check("product", int'(product), m_prod);
    check("product_valid", int'(product_valid), int'(m_valid));
    check("busy", int'(busy), int'(m_busy));
    check("step_count", int'(step_count), m_steps & 7);
    check("seq_error", int'(seq_error), int'(m_seq));
    check("overrun", int'(overrun), int'(m_over));
  endtask

  task automatic cycle(input bit i, input bit s, input bit k, input int a, input int b, input bit r);
    init = i; SR = s; product_ack = k; reset = r;
    multiplicand = W'(a); multiplier = W'(b);
    @(posedge clock);
    model(i, s, k, a, b, r);
    #1;
    check_all();
  endtask

  task automatic idle_cycle(input bit k);
    cycle(0, 0, k, $urandom_range(15), $urandom_range(15), 1);
  endtask

  // Controller pass: init, SR x(W-1), init+SR; operands driven only on the load cycle.
  task automatic do_mult(input int a, input int b, input bit ack_final);
    cycle(1, 0, 0, a, b, 1);
    for (int s = 0; s < W - 1; s++)
      cycle(0, 1, 0, $urandom_range(15), $urandom_range(15), 1);
    cycle(1, 1, ack_final, $urandom_range(15), $urandom_range(15), 1);
  endtask

  task automatic do_reset();
    cycle(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
  endtask

  initial begin
    vecs[0] = '{a: 13, b: 11, exp: 143};
    vecs[1] = '{a: 15, b: 15, exp: 225};
    vecs[2] = '{a: 0,  b: 9,  exp: 0};
    vecs[3] = '{a: 1,  b: 1,  exp: 1};
    vecs[4] = '{a: 9,  b: 0,  exp: 0};

    // Reset state
    do_reset();
    do_reset();
    check("reset_product", int'(product), 0);
    check("reset_valid", int'(product_valid), 0);

    // Directed vectors: result visible right after finalize, ack clears it next cycle
    foreach (vecs[n]) begin
      do_mult(vecs[n].a, vecs[n].b, 0);
      check("tbl_product", int'(product), vecs[n].exp);
      check("tbl_valid", int'(product_valid), 1);
      idle_cycle(1);
      check("tbl_valid_after_ack", int'(product_valid), 0);
      check("tbl_seq_error", int'(seq_error), 0);
    end

    // Randomized operands with random idle gaps and ack timing
    for (int n = 0; n < 40; n++) begin
      do_mult($urandom_range(15), $urandom_range(15), 1'($urandom_range(1)) & product_valid);
      for (int g = $urandom_range(3); g > 0; g--)
        idle_cycle(1'($urandom_range(1)));
      idle_cycle(1);
    end
    check("rand_no_seq_error", int'(seq_error), 0);
    check("rand_no_overrun", int'(overrun), 0);

    // Restart mid-multiply
    do_reset();
    cycle(1, 0, 0, 7, 7, 1);
    cycle(0, 1, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0, 1);
    do_mult(3, 5, 0);
    check("restart_product", int'(product), 15);
    check("restart_seq_error", int'(seq_error), 0);

    // Overwrite while unacked, then with ack on the finalize cycle
    do_reset();
    do_mult(2, 3, 0);
    do_mult(4, 5, 0);
    check("overrun_product", int'(product), 20);
    check("overrun_flag", int'(overrun), 1);
    do_reset();
    do_mult(2, 3, 0);
    do_mult(4, 5, 1);
    check("ackfinal_product", int'(product), 20);
    check("ackfinal_valid", int'(product_valid), 1);
    check("ackfinal_overrun", int'(overrun), 0);

    // Sequence errors
    do_reset();
    do_mult(6, 7, 0);
    idle_cycle(1);
    cycle(0, 1, 0, 0, 0, 1);
    check("sr_idle_seq_error", int'(seq_error), 1);
    check("sr_idle_product", int'(product), 42);
    check("sr_idle_valid", int'(product_valid), 0);
    do_reset();
    cycle(1, 0, 0, 5, 5, 1);
    cycle(0, 1, 0, 0, 0, 1);
    cycle(1, 1, 0, 0, 0, 1);
    check("early_final_seq_error", int'(seq_error), 1);
    check("early_final_valid", int'(product_valid), 0);
    check("early_final_product", int'(product), 0);
    check("early_final_busy", int'(busy), 0);
    // Last step without init
    do_reset();
    cycle(1, 0, 0, 5, 5, 1);
    for (int s = 0; s < W; s++) cycle(0, 1, 0, 0, 0, 1);
    check("missed_final_seq_error", int'(seq_error), 1);

    // Reset during step 2 abandons the multiply
    do_reset();
    do_mult(11, 3, 0);
    cycle(1, 0, 0, 9, 9, 1);
    cycle(0, 1, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0, 0);
    reset = 1'b1;
    check("midreset_product", int'(product), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_steps", int'(step_count), 0);

    // Reset pulse between clock edges must not clear anything
    do_mult(12, 12, 0);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async_pulse_product", int'(product), 144);
    check("async_pulse_valid", int'(product_valid), 1);
    idle_cycle(0);
    check("async_pulse_hold", int'(product), 144);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
